// File: rtl/data_ram_arb.sv
// Single-port word memory shared by the core and I/O channels, with fixed core priority,
// byte-enable writes, one-cycle registered reads and an optional clear-after-reset sweep.
module data_ram_arb #(
  parameter int LOGDEPTH   = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_rvalid,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_we,
  input  logic [3:0]  io_be,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  output logic        init_done
);
  localparam int DEPTH = 2 ** LOGDEPTH;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              state_reg;
  logic [LOGDEPTH-1:0] clr_idx_reg;

  logic [31:0] ram [DEPTH];

  logic                in_run;
  logic                core_acc;
  logic                io_acc;
  logic                core_rd;
  logic                io_rd;
  logic                acc_we;
  logic [3:0]          acc_be;
  logic [LOGDEPTH-1:0] acc_idx;
  logic [31:0]         acc_wdata;
  logic                mem_we;
  logic [LOGDEPTH-1:0] wr_idx;
  logic [3:0]          wr_be;
  logic [31:0]         wr_data;

  logic [31:0] core_rdata_reg;
  logic [31:0] io_rdata_reg;
  logic        core_rvalid_reg;
  logic        io_rvalid_reg;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_addr[31:LOGDEPTH+2], core_addr[1:0],
                              io_addr[31:LOGDEPTH+2], io_addr[1:0]};

  assign in_run         = (state_reg == ST_RUN) && !rst;
  assign core_req_ready = in_run;
  assign io_req_ready   = in_run && !core_req_valid;
  assign init_done      = in_run;

  assign core_acc = core_req_valid && core_req_ready;
  assign io_acc   = io_req_valid && io_req_ready;
  assign core_rd  = core_acc && !core_we;
  assign io_rd    = io_acc && !io_we;

  always_comb begin
    acc_we    = 1'b0;
    acc_be    = 4'b0000;
    acc_idx   = '0;
    acc_wdata = 32'h0;
    if (core_acc) begin
      acc_we    = core_we;
      acc_be    = core_be;
      acc_idx   = core_addr[LOGDEPTH+1:2];
      acc_wdata = core_wdata;
    end else if (io_acc) begin
      acc_we    = io_we;
      acc_be    = io_be;
      acc_idx   = io_addr[LOGDEPTH+1:2];
      acc_wdata = io_wdata;
    end
  end

  // The clearing sweep borrows the write port while requests are locked out.
  always_comb begin
    mem_we  = 1'b0;
    wr_idx  = acc_idx;
    wr_be   = acc_be;
    wr_data = acc_wdata;
    if (!rst) begin
      if (state_reg == ST_INIT) begin
        mem_we  = 1'b1;
        wr_idx  = clr_idx_reg;
        wr_be   = 4'b1111;
        wr_data = 32'h0;
      end else begin
        mem_we = (core_acc || io_acc) && acc_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= INIT_CLEAR ? ST_INIT : ST_RUN;
      clr_idx_reg <= '0;
    end else if (state_reg == ST_INIT) begin
      clr_idx_reg <= clr_idx_reg + {{(LOGDEPTH-1){1'b0}}, 1'b1};
      if (clr_idx_reg == {LOGDEPTH{1'b1}}) begin
        state_reg <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          ram[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Each channel keeps its own read register so the other channel never disturbs it.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rdata_reg  <= 32'h0;
      io_rdata_reg    <= 32'h0;
      core_rvalid_reg <= 1'b0;
      io_rvalid_reg   <= 1'b0;
    end else begin
      core_rvalid_reg <= core_rd;
      io_rvalid_reg   <= io_rd;
      if (core_rd) begin
        core_rdata_reg <= ram[acc_idx];
      end
      if (io_rd) begin
        io_rdata_reg <= ram[acc_idx];
      end
    end
  end

  assign core_rdata  = core_rdata_reg;
  assign io_rdata    = io_rdata_reg;
  assign core_rvalid = core_rvalid_reg;
  assign io_rvalid   = io_rvalid_reg;

endmodule

// File: doc/data_ram_arb.md
# data_ram_arb

Parametrised single-port data memory with a built-in two-channel arbiter (core pipeline and I/O loader), byte-enable writes, registered one-cycle-latency reads and a reset-time clearing sequencer. It replaces the fixed-depth, combinational-read data RAM and its mem/io mux wrapper in the memory stage. Depth is generic and storage maps onto block RAM: no asynchronous read, no single-cycle bulk reset.

## Interface
- LOGDEPTH, 8, log2 of depth in 32-bit words (DEPTH = 2**LOGDEPTH)
- INIT_CLEAR, 1, 1: zero every word after reset via sequencer; 0: contents untouched, RUN right after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- core_req_valid  in  1  core request present
- core_req_ready  out  1  core request accepted this cycle when valid&&ready
- core_we  in  1  1 write, 0 read
- core_be  in  4  byte enables, bit k = lane wdata[8k+7:8k]; ignored on reads
- core_addr  in  32  byte address
- core_wdata  in  32  write data
- core_rdata  out  32  read data
- core_rvalid  out  1  core_rdata valid, one-cycle pulse
- io_req_valid, io_req_ready, io_we, io_be, io_addr, io_wdata, io_rdata, io_rvalid: same widths and meanings for the I/O channel
- init_done  out  1  high in RUN

## Operation
- Word index = addr[LOGDEPTH+1:2]; addr[1:0] and addr[31:LOGDEPTH+2] ignored (aliasing and wrap, no error).
- States: INIT, RUN. rst forces INIT (or RUN if INIT_CLEAR=0) and clr_idx=0.
- INIT: each cycle with rst low, write 0 to ram[clr_idx], clr_idx+1; on the cycle writing DEPTH-1, go to RUN. No requests accepted.
- RUN: one access per cycle. core_req_ready = 1; io_req_ready = !core_req_valid (fixed core priority). Both ready forced 0 while rst high or in INIT.
- Accepted write: lanes with be[k]=1 updated, others kept; be=4'b0000 is accepted, no change, no rvalid.
- Accepted read: full word latched into that channel's rdata at the same edge; rvalid high the following cycle for one cycle.
- rdata holds the last read value until the next read on that channel; the other channel's traffic never changes it.
- Requester must hold valid and payload stable until accepted; the block does not queue.
- IO starvation under continuous core_req_valid is allowed.

## Timing
- Reset values (output during and right after rst): core_/io_req_ready 0, core_/io_rvalid 0, core_/io_rdata 32'h0, init_done 0 (1 if INIT_CLEAR=0 once rst low).
- INIT lasts exactly DEPTH cycles after first edge with rst low; init_done and core_req_ready rise in the next cycle.
- Read latency 1: accepted at edge N, rdata/rvalid valid in cycle after N, sampled at edge N+1.
- Back-to-back reads sustain one per cycle per accepted request; rvalid stays high across consecutive reads.
- Write at edge N, read of same word accepted at edge N+1 returns the new data (no stale read).
- rst mid-operation: any in-flight rvalid dropped (0 next cycle), rdata cleared, INIT restarts from clr_idx=0 even if previously partway through INIT.
- ready is combinational from state and core_req_valid; no combinational path from addr/wdata to any output.

## Test plan
- LOGDEPTH=4, INIT_CLEAR=1: write 0xDEADBEEF to all 16 words, pulse rst 1 cycle -> init_done rises exactly 16 cycles after rst low, reads of 0x00..0x3C all return 0x00000000.
- Write 0x11223344 to 0x20 be=1111, then 0xAABBCCDD be=0101, read 0x20 -> rdata 0x11BB33DD, rvalid one cycle; be=0000 write leaves 0x11BB33DD.
- Same cycle: core write 0x00000005 to 0x0, io read 0x0 -> core accepted cycle N, io_req_ready low in N, io accepted N+1, io_rdata 0x00000005 with io_rvalid in N+2; core_rvalid never pulses.
- LOGDEPTH=4: write 0xCAFE0001 to 0x40 -> read 0x00 and 0x03 both return 0xCAFE0001.
- Core reads 0x0, 0x4, 0x8 on consecutive cycles (words 1,2,3) -> core_rvalid high 3 consecutive cycles, data 1,2,3 in order, rdata holds 3 afterwards.
- Core read accepted at edge N, rst high sampled at N+1 -> core_rvalid 0, core_rdata 0, ready 0, INIT restarts and completes after DEPTH cycles.
